mm_seq_ctrl: RTL and testbench
==============================

# mm_seq_ctrl

Parametrised sequencer for the matrix-multiply datapath that computes C = A × B, where A is M×K and B is K×N.
- Replaces the hard-wired 25-state controller with a counter-driven FSM that has a start/busy/done handshake.
- Runs a validated operand-load phase, then schedules NUM_MAC parallel MAC lanes over column groups of each row.
- Drives operand-register selects, MAC clear/enable and the result-write strobe.
- Sits between the top-level command interface and the operand register file / MAC array / result store.

## Interface
- M, 3: rows of A and C (≥1)
- K, 2: inner dimension (≥1)
- N, 3: columns of B and C (≥1)
- NUM_MAC, 2: parallel MAC lanes (1..N)
- MAC_LAT, 1: cycles from the last MAC term issued to a valid MAC output (≥1)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a run; sampled only in IDLE
- skip_load  in  1  sampled with start; 1 = reuse the operands already loaded
- ld_valid  in  1  source presents the next operand element
- ld_en  out  1  operand register write enable (= ld_valid in LOAD)
- ld_addr  out  clog2(M*K+K*N)  operand index: A row-major at 0..M*K-1, then B row-major
- sel_a  out  clog2(M*K)  A element broadcast to all lanes
- sel_b  out  NUM_MAC*clog2(K*N)  per-lane B element index, lane 0 in the LSBs
- mac_clr  out  1  first term of a dot product: MAC loads the product instead of accumulating
- mac_en  out  NUM_MAC  per-lane accumulate enable
- res_valid  out  1  result group presented
- res_ready  in  1  result store accepts the group
- res_addr  out  clog2(M*N)  C index of lane 0 (row-major)
- res_mask  out  NUM_MAC  lanes holding valid results
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at run completion

## Operation
- States: IDLE, LOAD, COMPUTE, WAIT, RESULT, DONE.
- **IDLE**
  - start=1, skip_load=0 → LOAD.
  - start=1, skip_load=1 → COMPUTE.
  - start is ignored in every other state.
- **LOAD**
  - Each cycle with ld_valid=1: ld_en=1 with the current ld_addr, then ld_addr increments.
  - ld_valid=0 stalls the phase; ld_addr holds.
  - After index M*K+K*N-1 is accepted → COMPUTE.
- **Loop counters**
  - Row i runs 0..M-1; group base c0 runs 0, NUM_MAC, 2·NUM_MAC, … <N; k runs 0..K-1.
- **COMPUTE** (K cycles per group)
  - sel_a = i*K+k.
  - Lane l column = c0+l; lane valid iff c0+l<N.
  - sel_b[l] = k*N+c0+l for a valid lane, 0 otherwise.
  - mac_en = valid-lane mask; mac_clr=1 only when k=0.
  - After k=K-1 → WAIT.
- **WAIT**
  - MAC_LAT cycles; mac_en=0.
  - → RESULT.
- **RESULT**
  - res_valid=1, res_addr=i*N+c0, res_mask = valid-lane mask.
  - Leaves on res_ready=1.
  - Next group: → COMPUTE with c0 advanced; when c0 passes N, c0 wraps to 0 and i increments.
  - After the last group of row M-1 → DONE.
- **DONE**
  - done=1 for one cycle, then → IDLE.
- Outputs not listed for a state are 0.
- All index arithmetic uses the unsigned widths above; no index ever exceeds its range.

## Timing
- Reset: state IDLE and all counters 0 on the next rising edge.
  - Every output is 0 on reset, including ld_addr, sel_a, sel_b, res_addr and res_mask.
  - Reset mid-run aborts the run immediately; no done pulse is produced.
- Start to first LOAD cycle: 1 cycle.
- Start to first COMPUTE cycle with skip_load=1: 1 cycle.
- Per-group cost: K + MAC_LAT + (RESULT cycles, minimum 1).
- Full-bandwidth run (ld_valid and res_ready held high): done asserts at cycle 1 + (M*K+K*N) + G*(K+MAC_LAT+1) after start, with G = M*ceil(N/NUM_MAC).
- res_valid, res_addr and res_mask are held stable while res_ready=0.
- start asserted on the done cycle is ignored; it is accepted on the following (IDLE) cycle.

## Configuration
- MM_SEQ_RES_BACKPRESSURE_EN
  - Defined: RESULT waits for res_ready as described above.
  - Undefined: res_ready is ignored; RESULT lasts exactly one cycle and the result store must always accept.

## Structure
- Shared package mm_pkg holds:
  - the state enum mm_seq_state_t;
  - a clog2 constant function;
  - derived width localparams computed from M/K/N/NUM_MAC.
- One sub-module: mm_loop_ctr, the nested k / c0 / i counter.
  - Ports: step, clear, k_last, grp_last, run_last, and outputs k, c0, i.

## Test plan
- Defaults, ld_valid and res_ready held high, start at cycle 0 → ld_addr 0..11 on cycles 1..12; first mac_clr at cycle 13; 6 RESULT cycles; done at cycle 37.
- Partial group: row 0, c0=2 → sel_b = {0, 2} then {0, 5}, mac_en=2'b01, res_addr=2, res_mask=2'b01.
- Load stall: ld_valid low on cycles 3–5 → ld_addr frozen at 2; COMPUTE entry delayed by exactly 3 cycles.
- Backpressure (macro defined): res_ready low for 4 cycles in the first RESULT → res_valid and res_addr=0 held for 5 cycles; the remaining groups are unaffected.
- skip_load=1 with start → no ld_en; COMPUTE at cycle 1; done at cycle 25.
- Reset asserted in the third COMPUTE group, then start again → all outputs 0 the next cycle, no done pulse, and the restarted run is identical to the first scenario.

Source files
------------

// File: rtl/mm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mm_pkg
// Description : Shared definitions for the matrix-multiply sequencer.
//               Holds the sequencer state encoding, a ceil-log2 constant
//               function used to size every index port, and the default
//               problem dimensions with the index widths derived from them.
// Revision    : 1.0 - initial release
// ============================================================================
package mm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_WAIT    = 3'd3,
        ST_RESULT  = 3'd4,
        ST_DONE    = 3'd5
    } mm_seq_state_t;

    // Ceil-log2 with a floor of 1 bit, so a dimension of 1 still gets a
    // legal (one-bit) index vector.
    function automatic int mm_clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) width = width + 1;
        return width;
    endfunction

    // Default problem shape.
    localparam int c_def_m       = 3;
    localparam int c_def_k       = 2;
    localparam int c_def_n       = 3;
    localparam int c_def_num_mac = 2;
    localparam int c_def_mac_lat = 1;

    // Index widths for the default shape.
    localparam int c_def_ld_addr_w  = mm_clog2(c_def_m * c_def_k + c_def_k * c_def_n);
    localparam int c_def_sel_a_w    = mm_clog2(c_def_m * c_def_k);
    localparam int c_def_sel_b_w    = mm_clog2(c_def_k * c_def_n);
    localparam int c_def_res_addr_w = mm_clog2(c_def_m * c_def_n);

endpackage : mm_pkg
`default_nettype wire

// File: rtl/mm_loop_ctr.sv
`default_nettype none
// ============================================================================
// Module      : mm_loop_ctr
// Description : Nested loop counter for the sequencer: k (inner term),
//               c0 (column-group base, stride NUM_MAC) and i (row).
//               Each step advances k; stepping at k_last wraps k and moves
//               to the next column group, wrapping c0 into the next row.
//   clk, reset  : clock, synchronous active-high reset
//   step        : advance the nest by one position
//   clear       : force all counters to 0
//   k_last      : k is at K-1
//   grp_last    : current group is the last one of the row
//   run_last    : current group is the last one of the last row
//   k, c0, i    : current loop indices
// Revision    : 1.0 - initial release
// ============================================================================
module mm_loop_ctr import mm_pkg::*; #(
    parameter int M       = c_def_m,
    parameter int K       = c_def_k,
    parameter int N       = c_def_n,
    parameter int NUM_MAC = c_def_num_mac
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   step,
    input  logic                   clear,
    output logic                   k_last,
    output logic                   grp_last,
    output logic                   run_last,
    output logic [mm_clog2(K)-1:0] k,
    output logic [mm_clog2(N)-1:0] c0,
    output logic [mm_clog2(M)-1:0] i
);

    localparam int c_k_w  = mm_clog2(K);
    localparam int c_c0_w = mm_clog2(N);
    localparam int c_i_w  = mm_clog2(M);

    logic [c_k_w-1:0]  r_k;
    logic [c_c0_w-1:0] r_c0;
    logic [c_i_w-1:0]  r_i;
    logic              w_i_last;

    assign k_last   = (r_k == c_k_w'(K - 1));
    // Compared in 32 bits so c0 + NUM_MAC cannot wrap.
    assign grp_last = ((32'(r_c0) + 32'(NUM_MAC)) >= 32'(N));
    assign w_i_last = (r_i == c_i_w'(M - 1));
    assign run_last = grp_last & w_i_last;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_k  <= '0;
            r_c0 <= '0;
            r_i  <= '0;
        end else if (step) begin
            if (k_last) begin
                r_k <= '0;
                if (grp_last) begin
                    r_c0 <= '0;
                    r_i  <= w_i_last ? '0 : r_i + c_i_w'(1);
                end else begin
                    // Not the last group, so c0 + NUM_MAC < N fits in c0.
                    r_c0 <= r_c0 + c_c0_w'(NUM_MAC);
                end
            end else begin
                r_k <= r_k + c_k_w'(1);
            end
        end
    end

    assign k  = r_k;
    assign c0 = r_c0;
    assign i  = r_i;

endmodule : mm_loop_ctr
`default_nettype wire

// File: rtl/mm_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mm_seq_ctrl
// Description : Sequencer for the C = A x B matrix-multiply datapath.
//               Loads operands (A row-major, then B row-major), then for
//               each row walks column groups of NUM_MAC lanes: K MAC cycles,
//               MAC_LAT drain cycles, one result presentation.
//   clk, reset          : clock, synchronous active-high reset
//   start, skip_load    : run request (IDLE only); skip_load reuses operands
//   ld_valid/ld_en/ld_addr : operand load handshake and register index
//   sel_a, sel_b        : A element (broadcast) and per-lane B element
//   mac_clr, mac_en     : MAC first-term load and per-lane enable
//   res_valid/res_ready/res_addr/res_mask : result group to the store
//   busy, done          : not-IDLE flag, one-cycle completion pulse
// Build option: MM_SEQ_RES_BACKPRESSURE_EN - when defined the RESULT state
//               waits for res_ready; otherwise RESULT lasts one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mm_seq_ctrl import mm_pkg::*; #(
    parameter int M       = c_def_m,
    parameter int K       = c_def_k,
    parameter int N       = c_def_n,
    parameter int NUM_MAC = c_def_num_mac,
    parameter int MAC_LAT = c_def_mac_lat
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic                                  skip_load,
    input  logic                                  ld_valid,
    output logic                                  ld_en,
    output logic [mm_clog2(M*K+K*N)-1:0]          ld_addr,
    output logic [mm_clog2(M*K)-1:0]              sel_a,
    output logic [NUM_MAC*mm_clog2(K*N)-1:0]      sel_b,
    output logic                                  mac_clr,
    output logic [NUM_MAC-1:0]                    mac_en,
    output logic                                  res_valid,
    input  logic                                  res_ready,
    output logic [mm_clog2(M*N)-1:0]              res_addr,
    output logic [NUM_MAC-1:0]                    res_mask,
    output logic                                  busy,
    output logic                                  done
);

    localparam int c_ld_w   = mm_clog2(M * K + K * N);
    localparam int c_sa_w   = mm_clog2(M * K);
    localparam int c_sb_w   = mm_clog2(K * N);
    localparam int c_ra_w   = mm_clog2(M * N);
    localparam int c_k_w    = mm_clog2(K);
    localparam int c_c0_w   = mm_clog2(N);
    localparam int c_i_w    = mm_clog2(M);
    localparam int c_wait_w = mm_clog2(MAC_LAT);

    mm_seq_state_t r_state;
    mm_seq_state_t w_state_next;

    logic [c_ld_w-1:0]   r_ld_addr;
    logic [c_wait_w-1:0] r_wait_cnt;
    logic                w_ld_last;
    logic                w_wait_last;
    logic                w_res_accept;
    logic                w_step;
    logic                w_clear;
    logic                w_k_last;
    logic                w_grp_last;
    logic                w_run_last;
    logic [c_k_w-1:0]    w_k;
    logic [c_c0_w-1:0]   w_c0;
    logic [c_i_w-1:0]    w_i;
    logic [NUM_MAC-1:0]  w_lane_valid;
    logic [NUM_MAC*c_sb_w-1:0] w_sel_b;
    logic [c_sa_w-1:0]   w_sel_a;
    logic [c_ra_w-1:0]   w_res_addr;

`ifdef MM_SEQ_RES_BACKPRESSURE_EN
    assign w_res_accept = res_ready;
`else
    // The store always accepts; res_ready has no effect in this build and
    // the OR only keeps the port referenced.
    assign w_res_accept = 1'b1 | res_ready;
`endif

    assign w_ld_last   = (r_ld_addr == c_ld_w'(M * K + K * N - 1));
    assign w_wait_last = (r_wait_cnt == c_wait_w'(MAC_LAT - 1));

    // k holds at K-1 through WAIT and RESULT so the group indices stay put
    // for res_addr; the accepting RESULT cycle carries into the next group.
    assign w_step  = ((r_state == ST_COMPUTE) && !w_k_last) ||
                     ((r_state == ST_RESULT) && w_res_accept);
    assign w_clear = (r_state == ST_IDLE) && start;

    mm_loop_ctr #(
        .M       (M),
        .K       (K),
        .N       (N),
        .NUM_MAC (NUM_MAC)
    ) u_loop_ctr (
        .clk      (clk),
        .reset    (reset),
        .step     (w_step),
        .clear    (w_clear),
        .k_last   (w_k_last),
        .grp_last (w_grp_last),
        .run_last (w_run_last),
        .k        (w_k),
        .c0       (w_c0),
        .i        (w_i)
    );

    // Per-lane column validity and B index. Only the last group of a row
    // can be partial, so earlier groups have every lane valid.
    for (genvar l = 0; l < NUM_MAC; l++) begin : g_lane
        assign w_lane_valid[l] = !w_grp_last || ((32'(w_c0) + 32'(l)) < 32'(N));
        assign w_sel_b[l*c_sb_w +: c_sb_w] = w_lane_valid[l] ?
            (c_sb_w'(w_k) * c_sb_w'(N) + c_sb_w'(w_c0) + c_sb_w'(l)) : '0;
    end

    assign w_sel_a    = c_sa_w'(w_i) * c_sa_w'(K) + c_sa_w'(w_k);
    assign w_res_addr = c_ra_w'(w_i) * c_ra_w'(N) + c_ra_w'(w_c0);

    // Operand load index and WAIT-state drain counter.
    always_ff @(posedge clk) begin
        if (reset || w_clear) begin
            r_ld_addr <= '0;
        end else if ((r_state == ST_LOAD) && ld_valid) begin
            r_ld_addr <= w_ld_last ? '0 : r_ld_addr + c_ld_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || (r_state != ST_WAIT) || w_wait_last) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + c_wait_w'(1);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (start) w_state_next = skip_load ? ST_COMPUTE : ST_LOAD;
            ST_LOAD:    if (ld_valid && w_ld_last) w_state_next = ST_COMPUTE;
            ST_COMPUTE: if (w_k_last) w_state_next = ST_WAIT;
            ST_WAIT:    if (w_wait_last) w_state_next = ST_RESULT;
            ST_RESULT:  if (w_res_accept) w_state_next = w_run_last ? ST_DONE : ST_COMPUTE;
            ST_DONE:    w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // Output decode; every output not owned by the current state is 0.
    always_comb begin
        ld_en     = 1'b0;
        ld_addr   = '0;
        sel_a     = '0;
        sel_b     = '0;
        mac_clr   = 1'b0;
        mac_en    = '0;
        res_valid = 1'b0;
        res_addr  = '0;
        res_mask  = '0;
        done      = 1'b0;
        busy      = (r_state != ST_IDLE);
        case (r_state)
            ST_LOAD: begin
                ld_en   = ld_valid;
                ld_addr = r_ld_addr;
            end
            ST_COMPUTE: begin
                sel_a   = w_sel_a;
                sel_b   = w_sel_b;
                mac_en  = w_lane_valid;
                mac_clr = (w_k == '0);
            end
            ST_RESULT: begin
                res_valid = 1'b1;
                res_addr  = w_res_addr;
                res_mask  = w_lane_valid;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = (r_state != ST_IDLE);
            end
        endcase
    end

endmodule : mm_seq_ctrl
`default_nettype wire

// File: tb/tb_mm_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mm_seq_ctrl
// Description : Self-checking bench for mm_seq_ctrl at the default shape
//               (M=3, K=2, N=3, NUM_MAC=2, MAC_LAT=1). Expected MAC beats
//               and result groups are queued when a run starts and popped
//               as the sequencer produces them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mm_seq_ctrl;

    localparam int M = 3, K = 2, N = 3, NUM_MAC = 2, MAC_LAT = 1;
    localparam int LAW = 4, SAW = 3, SBW = 3, RAW = 4;
`ifdef MM_SEQ_RES_BACKPRESSURE_EN
    localparam bit BP = 1'b1;
`else
    localparam bit BP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, start, skip_load, ld_valid, res_ready;
    logic ld_en, mac_clr, res_valid, busy, done;
    logic [LAW-1:0] ld_addr;
    logic [SAW-1:0] sel_a;
    logic [NUM_MAC*SBW-1:0] sel_b;
    logic [NUM_MAC-1:0] mac_en, res_mask;
    logic [RAW-1:0] res_addr;
    logic [25:0] all_outs;

    always #5 clk = ~clk;

    mm_seq_ctrl #(.M(M), .K(K), .N(N), .NUM_MAC(NUM_MAC), .MAC_LAT(MAC_LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .skip_load(skip_load),
        .ld_valid(ld_valid), .ld_en(ld_en), .ld_addr(ld_addr),
        .sel_a(sel_a), .sel_b(sel_b), .mac_clr(mac_clr), .mac_en(mac_en),
        .res_valid(res_valid), .res_ready(res_ready), .res_addr(res_addr),
        .res_mask(res_mask), .busy(busy), .done(done)
    );

    assign all_outs = {ld_en, ld_addr, sel_a, sel_b, mac_clr, mac_en,
                       res_valid, res_addr, res_mask, busy, done};

    typedef struct packed {
        logic [SAW-1:0]         a;
        logic [NUM_MAC*SBW-1:0] b;
        logic [NUM_MAC-1:0]     en;
        logic                   clr;
    } beat_t;

    typedef struct packed {
        logic [RAW-1:0]     addr;
        logic [NUM_MAC-1:0] mask;
    } res_t;

    beat_t exp_beats[$], obs_beats[$];
    res_t  exp_res[$],   obs_res[$];

    int tests_run = 0, tests_failed = 0;
    int first_clr, done_cyc, done_cnt, res_cycles, ld_cnt;
    int ld_addr_at[0:63], ld_en_at[0:63], res_valid_at[0:63], res_addr_at[0:63];
    logic [25:0] outs_after_rst;

    // Reference schedule built from the loop definitions.
    task automatic push_expected();
        beat_t eb;
        res_t  er;
        for (int i = 0; i < M; i++) begin
            for (int c0 = 0; c0 < N; c0 += NUM_MAC) begin
                er.mask = '0;
                for (int l = 0; l < NUM_MAC; l++) if (c0 + l < N) er.mask[l] = 1'b1;
                er.addr = RAW'(i * N + c0);
                for (int k = 0; k < K; k++) begin
                    eb.a = SAW'(i * K + k);
                    eb.b = '0;
                    for (int l = 0; l < NUM_MAC; l++)
                        if (c0 + l < N) eb.b[l*SBW +: SBW] = SBW'(k * N + c0 + l);
                    eb.en  = er.mask;
                    eb.clr = (k == 0);
                    exp_beats.push_back(eb);
                end
                exp_res.push_back(er);
            end
        end
    endtask

    // One run: start at cycle 0, optional ld_valid stall window, res_ready
    // low for rdy_lo_len cycles from the first result, optional reset pulse.
    task automatic run(input bit skip, input int stall_lo, input int stall_hi,
                       input int rdy_lo_len, input int rst_at, input int max_cyc);
        int    first_res;
        beat_t ob, eb;
        res_t  orr, er;
        exp_beats.delete(); obs_beats.delete();
        exp_res.delete();   obs_res.delete();
        push_expected();
        first_clr = -1; done_cyc = -1; done_cnt = 0; res_cycles = 0; ld_cnt = 0;
        first_res = -1;
        outs_after_rst = '1;
        for (int c = 0; c < 64; c++) begin
            ld_addr_at[c] = -1; ld_en_at[c] = -1; res_valid_at[c] = -1; res_addr_at[c] = -1;
        end
        for (int c = 0; c <= max_cyc; c++) begin
            @(negedge clk);
            start     = (c == 0);
            skip_load = skip;
            ld_valid  = !(c >= stall_lo && c <= stall_hi);
            reset     = (c == rst_at);
            if (res_valid && first_res < 0) first_res = c;
            res_ready = !(first_res >= 0 && c < first_res + rdy_lo_len);
            #1;
            if (c < 64) begin
                ld_addr_at[c]   = int'(ld_addr);
                ld_en_at[c]     = int'(ld_en);
                res_valid_at[c] = int'(res_valid);
                res_addr_at[c]  = int'(res_addr);
            end
            if (ld_en) ld_cnt++;
            if (mac_clr && first_clr < 0) first_clr = c;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (res_valid) res_cycles++;
            if (c == rst_at + 1) outs_after_rst = all_outs;
            if (mac_en != '0) begin
                ob = {sel_a, sel_b, mac_en, mac_clr};
                obs_beats.push_back(ob);
                tests_run++;
                if (exp_beats.size() == 0) begin
                    tests_failed++;
                    $display("FAIL beat_extra cyc=%0d: got beat %h, required none", c, ob);
                end else begin
                    eb = exp_beats.pop_front();
                    if (ob !== eb) begin
                        tests_failed++;
                        $display("FAIL beat cyc=%0d: got %h, required %h", c, ob, eb);
                    end
                end
            end
            if (res_valid && (res_ready || !BP)) begin
                orr = {res_addr, res_mask};
                obs_res.push_back(orr);
                tests_run++;
                if (exp_res.size() == 0) begin
                    tests_failed++;
                    $display("FAIL result_extra cyc=%0d: got %h, required none", c, orr);
                end else begin
                    er = exp_res.pop_front();
                    if (orr !== er) begin
                        tests_failed++;
                        $display("FAIL result cyc=%0d: got %h, required %h", c, orr, er);
                    end
                end
            end
        end
        start = 1'b0; reset = 1'b0; res_ready = 1'b1; ld_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; skip_load = 1'b0; ld_valid = 1'b1; res_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if (all_outs !== 26'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h, required 0", all_outs);
        end
        reset = 1'b0; start = 1'b0;
        @(negedge clk); #1;
        tests_run++;
        if (all_outs !== 26'd0) begin
            tests_failed++;
            $display("FAIL idle_outputs: got %h, required 0", all_outs);
        end
    endtask

    task automatic check_common(input string name, input int exp_clr, input int exp_done,
                                input int exp_ld, input int exp_res_cyc);
        tests_run++;
        if (first_clr !== exp_clr) begin
            tests_failed++;
            $display("FAIL %s first_mac_clr: got %0d, required %0d", name, first_clr, exp_clr);
        end
        tests_run++;
        if (done_cyc !== exp_done || done_cnt !== 1) begin
            tests_failed++;
            $display("FAIL %s done: got cycle %0d count %0d, required cycle %0d count 1",
                     name, done_cyc, done_cnt, exp_done);
        end
        tests_run++;
        if (ld_cnt !== exp_ld) begin
            tests_failed++;
            $display("FAIL %s ld_en_count: got %0d, required %0d", name, ld_cnt, exp_ld);
        end
        tests_run++;
        if (res_cycles !== exp_res_cyc) begin
            tests_failed++;
            $display("FAIL %s res_valid_cycles: got %0d, required %0d", name, res_cycles, exp_res_cyc);
        end
        tests_run++;
        if (exp_beats.size() != 0 || exp_res.size() != 0) begin
            tests_failed++;
            $display("FAIL %s leftover: got %0d beats %0d results pending, required 0 0",
                     name, exp_beats.size(), exp_res.size());
        end
    endtask

    task automatic test_full_bandwidth(input string name);
        run(1'b0, 100, 100, 0, -10, 45);
        for (int c = 1; c <= 12; c++) begin
            tests_run++;
            if (ld_en_at[c] !== 1 || ld_addr_at[c] !== c - 1) begin
                tests_failed++;
                $display("FAIL %s ld_addr cyc=%0d: got en %0d addr %0d, required en 1 addr %0d",
                         name, c, ld_en_at[c], ld_addr_at[c], c - 1);
            end
        end
        check_common(name, 13, 37, 12, 6);
    endtask

    task automatic test_partial_group();
        beat_t b2, b3;
        res_t  r1;
        run(1'b1, 100, 100, 0, -10, 32);
        tests_run++;
        if (obs_beats.size() < 4 || obs_res.size() < 2) begin
            tests_failed++;
            $display("FAIL partial_count: got %0d beats %0d results, required >=4 >=2",
                     obs_beats.size(), obs_res.size());
        end else begin
            b2 = obs_beats[2]; b3 = obs_beats[3]; r1 = obs_res[1];
            tests_run++;
            if (b2.b !== 6'd2 || b3.b !== 6'd5 || b2.en !== 2'b01 || b3.en !== 2'b01) begin
                tests_failed++;
                $display("FAIL partial_sel_b: got %h/%h en %b/%b, required 02/05 en 01/01",
                         b2.b, b3.b, b2.en, b3.en);
            end
            tests_run++;
            if (r1.addr !== 4'd2 || r1.mask !== 2'b01) begin
                tests_failed++;
                $display("FAIL partial_result: got addr %0d mask %b, required addr 2 mask 01",
                         r1.addr, r1.mask);
            end
        end
    endtask

    task automatic test_skip_load();
        run(1'b1, 100, 100, 0, -10, 32);
        check_common("skip_load", 1, 25, 0, 6);
    endtask

    task automatic test_load_stall();
        run(1'b0, 3, 5, 0, -10, 50);
        for (int c = 3; c <= 5; c++) begin
            tests_run++;
            if (ld_en_at[c] !== 0 || ld_addr_at[c] !== 2) begin
                tests_failed++;
                $display("FAIL stall_hold cyc=%0d: got en %0d addr %0d, required en 0 addr 2",
                         c, ld_en_at[c], ld_addr_at[c]);
            end
        end
        check_common("load_stall", 16, 40, 12, 6);
    endtask

    task automatic test_backpressure();
        run(1'b0, 100, 100, 4, -10, 50);
`ifdef MM_SEQ_RES_BACKPRESSURE_EN
        for (int c = 16; c <= 20; c++) begin
            tests_run++;
            if (res_valid_at[c] !== 1 || res_addr_at[c] !== 0) begin
                tests_failed++;
                $display("FAIL bp_hold cyc=%0d: got valid %0d addr %0d, required valid 1 addr 0",
                         c, res_valid_at[c], res_addr_at[c]);
            end
        end
        check_common("backpressure", 13, 41, 12, 10);
`else
        tests_run++;
        if (res_valid_at[16] !== 1 || res_valid_at[17] !== 0) begin
            tests_failed++;
            $display("FAIL ready_ignored: got valid %0d,%0d at 16,17, required 1,0",
                     res_valid_at[16], res_valid_at[17]);
        end
        check_common("backpressure", 13, 37, 12, 6);
`endif
    endtask

    task automatic test_reset_midrun();
        run(1'b0, 100, 100, 0, 21, 30);
        tests_run++;
        if (outs_after_rst !== 26'd0) begin
            tests_failed++;
            $display("FAIL midrun_reset_outputs: got %h, required 0", outs_after_rst);
        end
        tests_run++;
        if (done_cnt !== 0) begin
            tests_failed++;
            $display("FAIL midrun_reset_done: got %0d pulses, required 0", done_cnt);
        end
        test_full_bandwidth("restart");
    endtask

    initial begin
        test_reset();
        test_full_bandwidth("full_bw");
        test_partial_group();
        test_load_stall();
        test_backpressure();
        test_skip_load();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_mm_seq_ctrl
`default_nettype wire
